// File: rtl/apb3_target_ram.sv
// APB3 completer backed by a word-addressed register file.
// Supports per-transfer wait states (sampled at setup), PSLVERR for unaligned or
// out-of-range accesses, and a saturating count of completed error transfers.
module apb3_target_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 48
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            WAIT_CFG,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic [7:0]            ERR_COUNT
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-3:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [7:0]              err_count_q, err_count_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-3:0]   idx;
    logic                    setup_err;

    assign idx       = PADDR[ADDR_WIDTH-1:2];
    // Decode is done once, at the setup edge; the index is held for the write commit.
    assign setup_err = (PADDR[1:0] != 2'b00) || (32'(idx) >= DEPTH);

    // Next-state logic: setup decode, wait countdown, completion and abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        idx_d       = idx_q;
        prdata_d    = prdata_q;
        err_count_d = err_count_q;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // PSEL with PENABLE already high is a protocol violation and is ignored.
                if (PSEL && !PENABLE) begin
                    state_d = StAccess;
                    cnt_d   = WAIT_CFG;
                    err_d   = setup_err;
                    idx_d   = idx;
                    if (!PWRITE) begin
                        prdata_d = setup_err ? '0 : mem[idx];
                    end
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                        if (err_q && (err_count_q != 8'hFF)) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        mem_we = PWRITE && !err_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            prdata_q    <= '0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            prdata_q    <= prdata_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[idx_q] <= PWDATA;
        end
    end

    assign PREADY    = (state_q == StAccess) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign PSLVERR   = PREADY && err_q;
    assign PRDATA    = prdata_q;
    assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_apb3_target_ram.sv
// Bench for apb3_target_ram: table of directed vectors, scoreboard of expected
// completions, plus hand-written abort, reset, back-to-back and saturation sequences.
module tb_apb3_target_ram;

    localparam int DEPTH = 48;

    logic        PCLK    = 1'b0;
    logic        PRESETN = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [7:0]  PADDR   = 8'h00;
    logic [31:0] PWDATA  = 32'h0;
    logic [3:0]  WAIT_CFG = 4'h0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [7:0]  ERR_COUNT;

    apb3_target_ram #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .WAIT_CFG  (WAIT_CFG),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .ERR_COUNT (ERR_COUNT)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        bit          err;
        int          cycles;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  wcfg;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_prdata = 32'h0;
    logic [7:0]  model_errcnt = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [7:0] a);
        return (a[1:0] != 2'b00) || (int'(a[7:2]) >= DEPTH);
    endfunction

    // One transfer starting with a setup cycle; leaves PSEL high so the next call
    // runs back-to-back. Returns what was observed on the completion cycle.
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wcfg, output logic [31:0] got_rdata,
                            output logic got_err);
        exp_t e;
        bit   er;
        int   cyc;
        bit   done;
        er = addr_err(addr);
        if (!wr) model_prdata = er ? 32'h0 : model_mem[addr[7:2]];
        e.wr = wr; e.rdata = model_prdata; e.err = er; e.cycles = int'(wcfg) + 1;
        sb.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        WAIT_CFG = wcfg;
        @(posedge PCLK); #1;
        PENABLE  = 1'b1;
        WAIT_CFG = ~wcfg;  // must not affect the transfer in flight
        cyc = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge PCLK);
            cyc++;
            if (PREADY) done = 1'b1;
            else check("pslverr_while_not_ready", {31'h0, PSLVERR}, 32'h0);
        end
        got_rdata = PRDATA;
        got_err   = PSLVERR;
        e = sb.pop_front();
        check("ready_cycles", cyc, e.cycles);
        check("pslverr", {31'h0, PSLVERR}, {31'h0, e.err});
        check(e.wr ? "prdata_hold" : "prdata", PRDATA, e.rdata);
        if (done) begin
            if (er && model_errcnt != 8'hFF) model_errcnt++;
            if (wr && !er) model_mem[addr[7:2]] = wdata;
        end
        @(posedge PCLK); #1;
    endtask

    task automatic go_idle();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    vec_t        tbl[17];
    logic [31:0] rd;
    logic        er;
    logic [31:0] v0, v1;
    logic [3:0]  w0, w1;

    initial begin
        tbl[0]  = '{1'b1, 8'h2C, 32'h0000_0001, 4'd0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 8'h2C, 32'h0,         4'd0,  1'b0, 32'h0000_0001};
        tbl[2]  = '{1'b1, 8'h18, 32'h0000_0003, 4'd3,  1'b0, 32'h0};
        tbl[3]  = '{1'b0, 8'h18, 32'h0,         4'd3,  1'b0, 32'h0000_0003};
        tbl[4]  = '{1'b1, 8'hC0, 32'h0000_DEAD, 4'd1,  1'b1, 32'h0};
        tbl[5]  = '{1'b0, 8'hC0, 32'h0,         4'd0,  1'b1, 32'h0};
        tbl[6]  = '{1'b0, 8'h05, 32'h0,         4'd2,  1'b1, 32'h0};
        tbl[7]  = '{1'b1, 8'h10, 32'hA5A5_0010, 4'd0,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 8'h10, 32'h0,         4'd1,  1'b0, 32'hA5A5_0010};
        tbl[9]  = '{1'b0, 8'h2C, 32'h0,         4'd15, 1'b0, 32'h0000_0001};
        tbl[10] = '{1'b1, 8'hBC, 32'h4747_4747, 4'd0,  1'b0, 32'h0};
        tbl[11] = '{1'b0, 8'hBC, 32'h0,         4'd0,  1'b0, 32'h4747_4747};
        tbl[12] = '{1'b1, 8'h00, 32'h0000_1234, 4'd2,  1'b0, 32'h0};
        tbl[13] = '{1'b1, 8'h02, 32'hFFFF_FFFF, 4'd0,  1'b1, 32'h0};
        tbl[14] = '{1'b0, 8'h00, 32'h0,         4'd0,  1'b0, 32'h0000_1234};
        tbl[15] = '{1'b0, 8'hFC, 32'h0,         4'd0,  1'b1, 32'h0};
        tbl[16] = '{1'b0, 8'h18, 32'h0,         4'd0,  1'b0, 32'h0000_0003};

        // Reset state
        #2 PRESETN = 1'b0;
        #2;
        check("reset_pready", {31'h0, PREADY}, 32'h0);
        check("reset_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_err_count", {24'h0, ERR_COUNT}, 32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        @(posedge PCLK); #1;

        // Directed table, all back-to-back
        for (int i = 0; i < 17; i++) begin
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].wcfg, rd, er);
            check($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
            if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end
        go_idle();
        check("err_count_after_table", {24'h0, ERR_COUNT}, {24'h0, model_errcnt});

        // Abort: PSEL dropped after 2 of 6 access cycles of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'hBAD0_0BAD;
        WAIT_CFG = 4'd5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            check("abort_pready_low", {31'h0, PREADY}, 32'h0);
            if (i == 0) begin
                @(posedge PCLK); #1;
            end
        end
        @(posedge PCLK); #1;
        go_idle();
        apb_xfer(1'b0, 8'h10, 32'h0, 4'd2, rd, er);
        check("abort_no_write", rd, 32'hA5A5_0010);
        go_idle();
        check("abort_err_count", {24'h0, ERR_COUNT}, {24'h0, model_errcnt});

        // Reset pulsed while a zero-wait write is in its completing access cycle
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h0000_BAD0;
        WAIT_CFG = 4'd0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        check("pre_reset_pready", {31'h0, PREADY}, 32'h1);
        PRESETN = 1'b0;
        #1;
        check("reset_drops_pready", {31'h0, PREADY}, 32'h0);
        check("reset_clears_prdata", PRDATA, 32'h0);
        check("reset_clears_err_count", {24'h0, ERR_COUNT}, 32'h0);
        model_prdata = 32'h0;
        model_errcnt = 8'h0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETN = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 8'h10, 32'h0, 4'd0, rd, er);
        check("reset_no_write", rd, 32'hA5A5_0010);
        go_idle();

        // Two writers back-to-back with random waits, then readbacks
        for (int k = 0; k < 4; k++) begin
            v0 = $urandom; v1 = $urandom;
            w0 = 4'($urandom_range(15)); w1 = 4'($urandom_range(15));
            apb_xfer(1'b1, 8'h2C, v0, w0, rd, er);
            apb_xfer(1'b1, 8'h18, v1, w1, rd, er);
            apb_xfer(1'b0, 8'h2C, 32'h0, 4'($urandom_range(15)), rd, er);
            check("b2b_read_2c", rd, v0);
            apb_xfer(1'b0, 8'h18, 32'h0, 4'($urandom_range(15)), rd, er);
            check("b2b_read_18", rd, v1);
            go_idle();
        end

        // 260 error transfers saturate the counter
        for (int k = 0; k < 260; k++) begin
            apb_xfer(1'b0, 8'h05, 32'h0, 4'd0, rd, er);
        end
        go_idle();
        check("err_count_model", {24'h0, ERR_COUNT}, {24'h0, model_errcnt});
        check("err_count_saturated", {24'h0, ERR_COUNT}, 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
